seq_mult_bcd: RTL and testbench
===============================

# seq_mult_bcd

Parametrised sequential shift-add multiplier with independent operand widths, selectable signed/unsigned mode, a start/busy/done handshake and an iterative binary-to-BCD stage that shows the product magnitude in decimal. It sits between the operand-entry logic and the display driver. It replaces the fixed-width unsigned multiplier: the multiply step and the BCD conversion are both multi-cycle and deterministic.

## Interface
- N_A, 8, width of operand a (≥2)
- N_B, 8, width of operand b (≥2); also the multiply-phase cycle count
- W, N_A+N_B, product width (derived, not overridable)
- BCD_D, (W/3)+1, number of BCD digits
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- signed_mode  input  1  1 = two's-complement operands; sampled with start
- a_in  input  N_A  multiplicand
- b_in  input  N_B  multiplier
- busy  output  1  operation in progress
- done  output  1  one-cycle completion pulse
- out  output  W  product (two's complement when signed_mode was 1)
- neg  output  1  product is negative
- bcd  output  4*BCD_D  BCD of |product|, digit 0 in bits [3:0]

## Operation
- States: IDLE, MUL, FIX, BCD.
- IDLE with start=1: capture a_in, b_in and signed_mode. In signed mode, capture |a| and |b| zero-extended, and latch sgn = a[msb]^b[msb]. In unsigned mode, sgn=0. Clear acc and load cnt=N_B. Go to MUL. busy=1.
- MUL: each cycle, if mb[0] then acc += ma (W-bit, no overflow possible). Then ma <<= 1, mb >>= 1, cnt--. Leave for FIX when cnt reaches 0.
- FIX: out <= sgn ? -acc : acc. neg <= sgn && acc!=0, so -0 reports neg=0. Load the converter with acc, which is the magnitude. Go to BCD.
- BCD: the converter runs W cycles of double dabble. Each cycle, every digit ≥5 gets +3, then the register shifts left 1 with the next magnitude bit, MSB first. All BCD_D digits are corrected.
- On the last BCD cycle: bcd <= converter result, done <= 1, busy <= 0, go to IDLE.
- Most-negative operands: |−2^(N−1)| = 2^(N−1) fits in the N-bit magnitude. −128×−128 = +16384 is handled exactly.
- start while busy is ignored, with no queueing. start in the cycle done is high is accepted because the block is in IDLE.
- out, neg and bcd hold their last values until the FIX/BCD of the next operation. out and neg update at FIX, bcd at completion.
- Reset, including mid-operation, clears everything immediately. State→IDLE. busy, done, neg = 0. out, bcd = 0. No done is issued for an aborted operation.

## Timing
- Capture edge = edge 0.
- Edges 1..N_B: MUL.
- Edge N_B+1: FIX. out and neg become valid.
- Edges N_B+2..N_B+W+1: BCD shifts.
- done is high for exactly the one cycle after edge L = N_B+W+1. For the 8×8 default, L = 25.
- busy is high from edge 0 until edge L, and falls on the same edge done rises.
- Back-to-back throughput: one result per L+1 cycles when start is held high.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Package mult_pkg holds:
  - the state encoding (IDLE/MUL/FIX/BCD)
  - the BCD_D derivation function
  - the add-3 threshold constant (5) and the correction value (3)
- Sub-module bin2bcd_seq has parameters W and BCD_D, and ports clk, reset, load, bin[W], busy, done, bcd. The top FSM sequences it.

## Test plan
- Unsigned 8×8, a=200, b=150 → out=16'h7530, neg=0, bcd=24'h030000, done exactly at edge 25.
- Signed a=8'hFD (−3), b=8'h05 → out=16'hFFF1, neg=1, bcd=24'h000015.
- Signed a=b=8'h80 (−128) → out=16'h4000, neg=0, bcd=24'h016384. Signed a=8'h80, b=0 → out=0, neg=0.
- Unsigned a=b=255 → out=16'hFE01, bcd=24'h065025. Pulsing start with other operands at edge 5 has no effect.
- reset low at edge 10 of an operation → busy=done=neg=0 and out=bcd=0 immediately, with no done afterwards. Then 0×77 → out=0, bcd=0.
- start held high through done with a new operand pair → second capture in the done cycle, second done L+1 cycles after the first. Repeat with N_A=12, N_B=4 (L=21, BCD_D=6).

Source files
------------

// File: rtl/seq_mult_bcd_pkg.sv
// Shared definitions for the sequential multiplier: FSM encoding,
// BCD digit-count derivation and the double-dabble correction constants.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIX  = 2'd2,
    BCD  = 2'd3
  } state_e;

  localparam logic [3:0] ADD3_THRESH = 4'd5;
  localparam logic [3:0] ADD3_VALUE  = 4'd3;

  // Enough decimal digits for any W-bit magnitude (each digit covers ~3.3 bits).
  function automatic int bcdDigits(input int w);
    return (w / 3) + 1;
  endfunction

endpackage

// File: rtl/seq_mult_bcd_bin2bcd.sv
// Iterative double-dabble converter: one bin bit per cycle, MSB first.
// The result register only changes on the final shift so it can drive a display directly.
module bin2bcd_seq
  import mult_pkg::*;
#(
  parameter int W     = 16,
  parameter int BCD_D = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [W-1:0]       bin,
  output logic               busy,
  output logic               done,
  output logic [4*BCD_D-1:0] bcd
);

  localparam int CW = $clog2(W + 1);
  localparam int BW = 4 * BCD_D;

  logic [W-1:0]  sh_q, sh_d;
  logic [BW-1:0] work_q, work_d, bcd_q, bcd_d;
  logic [BW-1:0] corr, shifted;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    corr = work_q;
    for (int i = 0; i < BCD_D; i++) begin
      if (work_q[4*i +: 4] >= ADD3_THRESH) begin
        corr[4*i +: 4] = work_q[4*i +: 4] + ADD3_VALUE;
      end
    end
    shifted = {corr[BW-2:0], sh_q[W-1]};

    sh_d   = sh_q;
    work_d = work_q;
    cnt_d  = cnt_q;
    bcd_d  = bcd_q;
    if (load) begin
      sh_d   = bin;
      work_d = '0;
      cnt_d  = CW'(W);
    end else if (cnt_q != '0) begin
      sh_d   = sh_q << 1;
      work_d = shifted;
      cnt_d  = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        bcd_d = shifted;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_q   <= '0;
      work_q <= '0;
      cnt_q  <= '0;
      bcd_q  <= '0;
    end else begin
      sh_q   <= sh_d;
      work_q <= work_d;
      cnt_q  <= cnt_d;
      bcd_q  <= bcd_d;
    end
  end

  // done marks the cycle whose closing edge performs the final shift.
  assign busy = (cnt_q != '0);
  assign done = (cnt_q == CW'(1));
  assign bcd  = bcd_q;

endmodule

// File: rtl/seq_mult_bcd.sv
// Sequential shift-add multiplier (signed/unsigned) with start/busy/done handshake
// and a decimal readout of the product magnitude.
module seq_mult_bcd
  import mult_pkg::*;
#(
  parameter int N_A = 8,
  parameter int N_B = 8
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic                                   signed_mode,
  input  logic [N_A-1:0]                         a_in,
  input  logic [N_B-1:0]                         b_in,
  output logic                                   busy,
  output logic                                   done,
  output logic [N_A+N_B-1:0]                     out,
  output logic                                   neg,
  output logic [4*bcdDigits(N_A+N_B)-1:0]        bcd
);

  localparam int W     = N_A + N_B;
  localparam int BCD_D = bcdDigits(W);
  localparam int CW    = $clog2(N_B + 1);

  state_e         state_q, state_d;
  logic [W-1:0]   ma_q, ma_d, acc_q, acc_d, out_q, out_d;
  logic [N_B-1:0] mb_q, mb_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           sgn_q, sgn_d, neg_q, neg_d;
  logic           busy_q, busy_d, done_q, done_d;
  logic [N_A-1:0] aMag;
  logic [N_B-1:0] bMag;
  logic           binLoad, binBusy, binLast;

  // Operands are multiplied as magnitudes; the most-negative value maps to
  // 2^(N-1), which still fits the unsigned N-bit magnitude.
  always_comb begin
    aMag = (signed_mode && a_in[N_A-1]) ? -a_in : a_in;
    bMag = (signed_mode && b_in[N_B-1]) ? -b_in : b_in;

    state_d = state_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    out_d   = out_q;
    neg_d   = neg_q;
    done_d  = 1'b0;
    binLoad = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          ma_d    = {{N_B{1'b0}}, aMag};
          mb_d    = bMag;
          sgn_d   = signed_mode & (a_in[N_A-1] ^ b_in[N_B-1]);
          acc_d   = '0;
          cnt_d   = CW'(N_B);
          state_d = MUL;
        end
      end
      MUL: begin
        if (mb_q[0]) begin
          acc_d = acc_q + ma_q;
        end
        ma_d  = ma_q << 1;
        mb_d  = mb_q >> 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        out_d   = sgn_q ? -acc_q : acc_q;
        neg_d   = sgn_q && (acc_q != '0);
        binLoad = 1'b1;
        state_d = BCD;
      end
      BCD: begin
        if (binBusy && binLast) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ma_q    <= '0;
      mb_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      out_q   <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      out_q   <= out_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  bin2bcd_seq #(
    .W    (W),
    .BCD_D(BCD_D)
  ) u_bin2bcd (
    .clk  (clk),
    .reset(reset),
    .load (binLoad),
    .bin  (acc_q),
    .busy (binBusy),
    .done (binLast),
    .bcd  (bcd)
  );

  assign busy = busy_q;
  assign done = done_q;
  assign out  = out_q;
  assign neg  = neg_q;

endmodule

// File: tb/tb_seq_mult_bcd.sv
// Scoreboard bench for seq_mult_bcd: an 8x8 instance and a 12x4 instance,
// expected results queued at issue time and checked whenever done pulses.
module tb_seq_mult_bcd;

  localparam int L1 = 25;
  localparam int L2 = 21;

  typedef struct {
    logic [15:0] out;
    logic        neg;
    logic [23:0] bcd;
    int          doneAt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start1, sm1, busy1, done1, neg1;
  logic [7:0]  a1, b1;
  logic [15:0] out1;
  logic [23:0] bcd1;
  logic        start2, sm2, busy2, done2, neg2;
  logic [11:0] a2;
  logic [3:0]  b2;
  logic [15:0] out2;
  logic [23:0] bcd2;

  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  exp_t q1[$];
  exp_t q2[$];

  seq_mult_bcd #(.N_A(8), .N_B(8)) dut1 (
    .clk(clk), .reset(rst_n), .start(start1), .signed_mode(sm1),
    .a_in(a1), .b_in(b1), .busy(busy1), .done(done1),
    .out(out1), .neg(neg1), .bcd(bcd1)
  );

  seq_mult_bcd #(.N_A(12), .N_B(4)) dut2 (
    .clk(clk), .reset(rst_n), .start(start2), .signed_mode(sm2),
    .a_in(a2), .b_in(b2), .busy(busy2), .done(done2),
    .out(out2), .neg(neg2), .bcd(bcd2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
  endtask

  // Monitor side: pop the oldest expectation for the instance that pulsed done.
  task automatic scoreDone(input int which);
    exp_t        e;
    logic [15:0] o;
    logic        n, bz;
    logic [23:0] bb;
    int          sz;
    if (which == 1) begin
      o = out1; n = neg1; bb = bcd1; bz = busy1; sz = q1.size();
    end else begin
      o = out2; n = neg2; bb = bcd2; bz = busy2; sz = q2.size();
    end
    if (sz == 0) begin
      checks++;
      $display("[TB] FAIL unexpectedDone dut%0d: done=1 at edge %0d, required 0", which, cyc);
    end else begin
      if (which == 1) e = q1.pop_front();
      else e = q2.pop_front();
      checkOutput($sformatf("dut%0d.out", which), {16'd0, o}, {16'd0, e.out});
      checkOutput($sformatf("dut%0d.neg", which), {31'd0, n}, {31'd0, e.neg});
      checkOutput($sformatf("dut%0d.bcd", which), {8'd0, bb}, {8'd0, e.bcd});
      checkOutput($sformatf("dut%0d.doneEdge", which), cyc, e.doneAt);
      checkOutput($sformatf("dut%0d.busyAtDone", which), {31'd0, bz}, 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (done1 === 1'b1) scoreDone(1);
      if (done2 === 1'b1) scoreDone(2);
    end
  end

  task automatic waitIdle(input int which);
    int n = 0;
    @(negedge clk);
    while (((which == 1) ? busy1 : busy2) !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      $display("[TB] FAIL idleTimeout dut%0d: busy=1 after 200 cycles, required 0", which);
    end
  endtask

  task automatic waitDone(input int which);
    int n = 0;
    while (((which == 1) ? done1 : done2) !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      $display("[TB] FAIL doneTimeout dut%0d: done=0 after 100 cycles, required 1", which);
    end
  endtask

  // Issue one operation from a negedge; hold keeps start high after capture.
  task automatic applyStimulus(input int which, input logic sm, input logic [11:0] a,
                               input logic [7:0] b, input logic [15:0] eo, input logic en,
                               input logic [23:0] eb, input bit hold, output int doneAt);
    exp_t e;
    waitIdle(which);
    e.out = eo; e.neg = en; e.bcd = eb;
    e.doneAt = cyc + 1 + ((which == 1) ? L1 : L2);
    doneAt = e.doneAt;
    if (which == 1) begin
      sm1 = sm; a1 = a[7:0]; b1 = b; start1 = 1'b1; q1.push_back(e);
    end else begin
      sm2 = sm; a2 = a; b2 = b[3:0]; start2 = 1'b1; q2.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    if (!hold) begin
      if (which == 1) start1 = 1'b0;
      else start2 = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int   d;
    exp_t e;
    rst_n = 1'b0;
    start1 = 0; sm1 = 0; a1 = 0; b1 = 0;
    start2 = 0; sm2 = 0; a2 = 0; b2 = 0;
    repeat (3) @(negedge clk);
    checkOutput("reset.busy1", {31'd0, busy1}, 32'd0);
    checkOutput("reset.done1", {31'd0, done1}, 32'd0);
    checkOutput("reset.out1", {16'd0, out1}, 32'd0);
    checkOutput("reset.bcd1", {8'd0, bcd1}, 32'd0);
    checkOutput("reset.busy2", {31'd0, busy2}, 32'd0);
    rst_n = 1'b1;

    applyStimulus(1, 1'b0, 12'd200, 8'd150, 16'h7530, 1'b0, 24'h030000, 1'b0, d);
    applyStimulus(1, 1'b1, 12'h0FD, 8'h05, 16'hFFF1, 1'b1, 24'h000015, 1'b0, d);
    applyStimulus(1, 1'b1, 12'h080, 8'h80, 16'h4000, 1'b0, 24'h016384, 1'b0, d);
    applyStimulus(1, 1'b1, 12'h080, 8'h00, 16'h0000, 1'b0, 24'h000000, 1'b0, d);

    // A start pulse at edge 5 of a running operation must be ignored.
    applyStimulus(1, 1'b0, 12'h0FF, 8'hFF, 16'hFE01, 1'b0, 24'h065025, 1'b0, d);
    repeat (4) @(negedge clk);
    a1 = 8'h12; b1 = 8'h34; sm1 = 1'b1; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;

    // Abort a signed operation just after its FIX edge.
    applyStimulus(1, 1'b1, 12'h0FD, 8'h05, 16'hFFF1, 1'b1, 24'h000015, 1'b0, d);
    repeat (9) @(negedge clk);
    checkOutput("preAbort.out1", {16'd0, out1}, 32'h0000FFF1);
    checkOutput("preAbort.neg1", {31'd0, neg1}, 32'd1);
    rst_n = 1'b0;
    q1.delete();
    #1;
    checkOutput("abort.busy1", {31'd0, busy1}, 32'd0);
    checkOutput("abort.done1", {31'd0, done1}, 32'd0);
    checkOutput("abort.neg1", {31'd0, neg1}, 32'd0);
    checkOutput("abort.out1", {16'd0, out1}, 32'd0);
    checkOutput("abort.bcd1", {8'd0, bcd1}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    applyStimulus(1, 1'b0, 12'h000, 8'h77, 16'h0000, 1'b0, 24'h000000, 1'b0, d);

    // Back-to-back: second operand pair captured in the done cycle.
    applyStimulus(1, 1'b0, 12'd12, 8'd34, 16'h0198, 1'b0, 24'h000408, 1'b1, d);
    sm1 = 1'b1; a1 = 8'h7F; b1 = 8'h81;
    e.out = 16'hC0FF; e.neg = 1'b1; e.bcd = 24'h016129; e.doneAt = d + L1 + 1;
    q1.push_back(e);
    waitDone(1);
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;

    applyStimulus(2, 1'b1, 12'h800, 8'h07, 16'hC800, 1'b1, 24'h014336, 1'b0, d);
    applyStimulus(2, 1'b1, 12'hFFF, 8'h08, 16'h0008, 1'b0, 24'h000008, 1'b1, d);
    sm2 = 1'b0; a2 = 12'hFFF; b2 = 4'hF;
    e.out = 16'hEFF1; e.neg = 1'b0; e.bcd = 24'h061425; e.doneAt = d + L2 + 1;
    q2.push_back(e);
    waitDone(2);
    @(posedge clk);
    @(negedge clk);
    start2 = 1'b0;

    waitIdle(1);
    waitIdle(2);
    repeat (5) @(negedge clk);
    checkOutput("pending.dut1", q1.size(), 32'd0);
    checkOutput("pending.dut2", q2.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
